sop_sweep_capture: RTL and testbench

- Sequential exerciser and reader for the team's 5-variable sum-of-products network (product terms over X, Y, Z, K, M, OR-combined into a single output F).
- On `start`, it drives all 32 input combinations with true and complemented rails and samples the returned F for each.
- It assembles a 32-bit truth table and a ones count.
- It sits on the opposite side of the combinational SOP block: that block consumes variables and produces F; this block produces variables and consumes F.

---
 rtl/sop_sweep_capture.sv | 157 +++++++++++++++
 tb/tb_sop_sweep_capture.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sop_sweep_capture.sv
// Sweeps all 32 {X,Y,Z,K,M} vectors with true/complement rails into an SOP network and captures F.
// Optional golden-model comparison is enabled with SOP_SELFCHECK_EN (adds mismatch/first_fail ports).
module sop_sweep_capture #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f_in,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        K,
    output logic        M,
    output logic        noX,
    output logic        noY,
    output logic        noZ,
    output logic        noK,
    output logic        noM,
    output logic        busy,
    output logic        done,
    output logic [31:0] truth_table,
    output logic [5:0]  ones_count
`ifdef SOP_SELFCHECK_EN
    ,
    output logic        mismatch,
    output logic [4:0]  first_fail
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SAMPLE, S_DONE} state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE_CYC);

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] tt_q, tt_d;
    logic [5:0]  ones_q, ones_d;
    logic [4:0]  rail_q, rail_d;
    logic [4:0]  nrail_q, nrail_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept;
    logic        sample;

    assign accept = (state_q == S_IDLE) && start;
    assign sample = (state_q == S_HOLD) && (cnt_q == SETTLE_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            rail_q  <= '0;
            nrail_q <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            rail_q  <= rail_d;
            nrail_q <= nrail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_HOLD;
            S_HOLD:   if (sample) state_d = S_SAMPLE;
            S_SAMPLE: state_d = (idx_q == 5'd31) ? S_DONE : S_HOLD;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        tt_d   = tt_q;
        ones_d = ones_q;
        if (accept) begin
            idx_d  = '0;
            cnt_d  = '0;
            tt_d   = '0;
            ones_d = '0;
        end else if (state_q == S_HOLD) begin
            cnt_d = cnt_q + 4'd1;
            if (sample) begin
                tt_d[idx_q] = f_in;
                ones_d      = ones_q + {5'd0, f_in};
            end
        end else if (state_q == S_SAMPLE && idx_q != 5'd31) begin
            idx_d = idx_q + 5'd1;
            cnt_d = '0;
        end
    end

    // Both rail sets load from the next index so they flip on the same edge.
    always_comb begin
        rail_d  = idx_d;
        nrail_d = ~idx_d;
        busy_d  = (state_d == S_HOLD) || (state_d == S_SAMPLE);
        done_d  = (state_d == S_DONE);
    end

    assign {X, Y, Z, K, M}           = rail_q;
    assign {noX, noY, noZ, noK, noM} = nrail_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
    assign ones_count  = ones_q;

`ifdef SOP_SELFCHECK_EN
    logic       mismatch_q, mismatch_d;
    logic [4:0] first_fail_q, first_fail_d;
    logic       gx, gy, gz, gk, gm, golden;

    assign {gx, gy, gz, gk, gm} = idx_q;
    assign golden = (gy & gk & gm) | (gz & ~gm) | (gx & ~gy & gk & ~gz)
                  | (~gx & gk & ~gz) | (~gy & ~gz) | (gx & ~gz & gm);

    always_comb begin
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;
        if (accept) begin
            mismatch_d   = 1'b0;
            first_fail_d = '0;
        end else if (sample && (f_in != golden)) begin
            mismatch_d = 1'b1;
            if (!mismatch_q) first_fail_d = idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q   <= 1'b0;
            first_fail_q <= '0;
        end else begin
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign mismatch   = mismatch_q;
    assign first_fail = first_fail_q;
`endif

endmodule

// File: tb/tb_sop_sweep_capture.sv
// Scoreboard bench for sop_sweep_capture: SETTLE_CYC=1 main instance plus a SETTLE_CYC=0 instance.
module tb_sop_sweep_capture;

    typedef struct {
        logic [31:0] tt;
        logic [5:0]  ones;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic f_in;
    logic f_in2 = 1'b0;
    int   mode = 1;

    logic X, Y, Z, K, M, noX, noY, noZ, noK, noM, busy, done;
    logic [31:0] truth_table;
    logic [5:0]  ones_count;
    logic X2, Y2, Z2, K2, M2, noX2, noY2, noZ2, noK2, noM2, busy2, done2;
    logic [31:0] truth_table2;
    logic [5:0]  ones_count2;
`ifdef SOP_SELFCHECK_EN
    logic       mismatch, mismatch2;
    logic [4:0] first_fail, first_fail2;
`endif

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    function automatic logic sop_f(logic [4:0] v);
        logic x, y, z, k, m;
        {x, y, z, k, m} = v;
        return (y & k & m) | (z & ~m) | (x & ~y & k & ~z) | (~x & k & ~z) | (~y & ~z) | (x & ~z & m);
    endfunction

    function automatic logic [31:0] tt_for(int md);
        logic [31:0] t = '0;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v = 5'(i);
            case (md)
                0: t[i] = 1'b0;
                1: t[i] = 1'b1;
                2: t[i] = v[4];
                3: t[i] = v[0];
                default: t[i] = sop_f(v);
            endcase
        end
        return t;
    endfunction

    always_comb begin
        case (mode)
            0: f_in = 1'b0;
            1: f_in = 1'b1;
            2: f_in = X;
            3: f_in = M;
            default: f_in = sop_f({X, Y, Z, K, M});
        endcase
    end

    sop_sweep_capture #(.SETTLE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in),
        .X(X), .Y(Y), .Z(Z), .K(K), .M(M),
        .noX(noX), .noY(noY), .noZ(noZ), .noK(noK), .noM(noM),
        .busy(busy), .done(done), .truth_table(truth_table), .ones_count(ones_count)
`ifdef SOP_SELFCHECK_EN
        , .mismatch(mismatch), .first_fail(first_fail)
`endif
    );

    sop_sweep_capture #(.SETTLE_CYC(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .f_in(f_in2),
        .X(X2), .Y(Y2), .Z(Z2), .K(K2), .M(M2),
        .noX(noX2), .noY(noY2), .noZ(noZ2), .noK(noK2), .noM(noM2),
        .busy(busy2), .done(done2), .truth_table(truth_table2), .ones_count(ones_count2)
`ifdef SOP_SELFCHECK_EN
        , .mismatch(mismatch2), .first_fail(first_fail2)
`endif
    );

    function automatic exp_t mk_exp(int md);
        exp_t e;
        e.tt   = tt_for(md);
        e.ones = 6'($countones(e.tt));
        return e;
    endfunction

    // Stimulus only: pulse start, then count busy cycles until done (bounded).
    task automatic sweep(input int md, output int busy_cyc, output bit timed_out);
        mode = md;
        exp_q.push_back(mk_exp(md));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        busy_cyc = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({X, Y, Z, K, M, noX, noY, noZ, noK, noM} !== 10'b00000_11111) begin
            errors++;
            $display("FAIL reset_rails: got %b expected 0000011111", {X, Y, Z, K, M, noX, noY, noZ, noK, noM});
        end
        checks++;
        if ({busy, done, truth_table, ones_count} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b tt=%h ones=%0d expected all 0", busy, done, truth_table, ones_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        exp_t e;
        int busy_cyc = 0;
        int rail_bad = 0;
        bit timed_out = 1'b1;
        mode = 1;
        exp_q.push_back(mk_exp(1));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ({noX, noY, noZ, noK, noM} !== ~{X, Y, Z, K, M}) rail_bad++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL ones_timeout: no done within 400 cycles");
        end
        checks++;
        if (busy_cyc != 96) begin
            errors++;
            $display("FAIL ones_busy_len: got %0d expected 96", busy_cyc);
        end
        checks++;
        if (rail_bad != 0) begin
            errors++;
            $display("FAIL complement_rails: %0d bad cycles expected 0", rail_bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_done: got %b expected 0", busy);
        end
        checks++;
        if (truth_table !== e.tt || ones_count !== e.ones) begin
            errors++;
            $display("FAIL ones_result: tt=%h ones=%0d expected tt=%h ones=%0d", truth_table, ones_count, e.tt, e.ones);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: done=%b one cycle later, expected 0", done);
        end
        checks++;
        if (truth_table !== e.tt || ones_count !== e.ones) begin
            errors++;
            $display("FAIL result_hold: tt=%h ones=%0d expected tt=%h ones=%0d", truth_table, ones_count, e.tt, e.ones);
        end
    endtask

    task automatic test_patterns();
        exp_t e;
        int busy_cyc;
        bit timed_out;
        for (int md = 2; md <= 4; md++) begin
            sweep(md, busy_cyc, timed_out);
            e = exp_q.pop_front();
            checks++;
            if (timed_out || busy_cyc != 96) begin
                errors++;
                $display("FAIL pattern%0d_len: busy=%0d timeout=%b expected 96 no timeout", md, busy_cyc, timed_out);
            end
            checks++;
            if (truth_table !== e.tt || ones_count !== e.ones) begin
                errors++;
                $display("FAIL pattern%0d_result: tt=%h ones=%0d expected tt=%h ones=%0d", md, truth_table, ones_count, e.tt, e.ones);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int busy_cyc = 0;
        bit timed_out = 1'b1;
        mode = 2;
        exp_q.push_back(mk_exp(2));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            start = (cyc == 10 || cyc == 50);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (timed_out || busy_cyc != 96) begin
            errors++;
            $display("FAIL ignore_start_len: busy=%0d timeout=%b expected 96 no timeout", busy_cyc, timed_out);
        end
        checks++;
        if (truth_table !== e.tt || ones_count !== e.ones) begin
            errors++;
            $display("FAIL ignore_start_result: tt=%h ones=%0d expected tt=%h ones=%0d", truth_table, ones_count, e.tt, e.ones);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int done_at[2];
        int n = 0;
        mode = 3;
        exp_q.push_back(mk_exp(3));
        exp_q.push_back(mk_exp(3));
        @(negedge clk) start = 1'b1;
        for (int cyc = 0; cyc < 500 && n < 2; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_at[n] = cyc;
                n++;
                if (n == 2) start = 1'b0;
                e = exp_q.pop_front();
                checks++;
                if (truth_table !== e.tt || ones_count !== e.ones) begin
                    errors++;
                    $display("FAIL b2b_result%0d: tt=%h ones=%0d expected tt=%h ones=%0d", n, truth_table, ones_count, e.tt, e.ones);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses expected 2", n);
        end else begin
            checks++;
            if (done_at[1] - done_at[0] != 98) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d expected 98", done_at[1] - done_at[0]);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: busy=%b after start released, expected 0", busy);
        end
    endtask

    task automatic test_settle0();
        int busy_cyc = 0;
        bit timed_out = 1'b1;
        exp_t e;
        exp_q.push_back(mk_exp(0));
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done2) begin
                timed_out = 1'b0;
                break;
            end
            if (busy2) busy_cyc++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if (timed_out || busy_cyc != 64) begin
            errors++;
            $display("FAIL settle0_len: busy=%0d timeout=%b expected 64 no timeout", busy_cyc, timed_out);
        end
        checks++;
        if (truth_table2 !== e.tt || ones_count2 !== e.ones) begin
            errors++;
            $display("FAIL settle0_result: tt=%h ones=%0d expected tt=%h ones=%0d", truth_table2, ones_count2, e.tt, e.ones);
        end
        checks++;
        if ({noX2, noY2, noZ2, noK2, noM2} !== ~{X2, Y2, Z2, K2, M2}) begin
            errors++;
            $display("FAIL settle0_rails: true=%b comp=%b", {X2, Y2, Z2, K2, M2}, {noX2, noY2, noZ2, noK2, noM2});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        exp_t e;
        int busy_cyc;
        bit timed_out;
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({X, Y, Z, K, M, noX, noY, noZ, noK, noM} !== 10'b00000_11111 ||
            {busy, done, truth_table, ones_count} !== 40'd0) begin
            errors++;
            $display("FAIL mid_reset_values: rails=%b busy=%b done=%b tt=%h ones=%0d expected reset values",
                     {X, Y, Z, K, M, noX, noY, noZ, noK, noM}, busy, done, truth_table, ones_count);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++;
        if (done_seen != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_nodone: done pulses=%0d busy=%b expected 0 and 0", done_seen, busy);
        end
        sweep(3, busy_cyc, timed_out);
        e = exp_q.pop_front();
        checks++;
        if (timed_out || busy_cyc != 96 || truth_table !== e.tt || ones_count !== e.ones) begin
            errors++;
            $display("FAIL mid_reset_resweep: busy=%0d tt=%h ones=%0d expected 96 tt=%h ones=%0d",
                     busy_cyc, truth_table, ones_count, e.tt, e.ones);
        end
        @(negedge clk);
    endtask

`ifdef SOP_SELFCHECK_EN
    task automatic test_selfcheck();
        int busy_cyc;
        bit timed_out;
        exp_t e;
        sweep(4, busy_cyc, timed_out);
        e = exp_q.pop_front();
        checks++;
        if (timed_out || mismatch !== 1'b0 || truth_table !== e.tt) begin
            errors++;
            $display("FAIL selfcheck_real: mismatch=%b tt=%h expected mismatch=0 tt=%h", mismatch, truth_table, e.tt);
        end
        @(negedge clk);
        sweep(0, busy_cyc, timed_out);
        e = exp_q.pop_front();
        checks++;
        if (timed_out || mismatch !== 1'b1 || first_fail !== 5'd0) begin
            errors++;
            $display("FAIL selfcheck_tied0: mismatch=%b first_fail=%0d expected 1 and 0", mismatch, first_fail);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_ignore_start();
        test_back_to_back();
        test_settle0();
        test_reset_mid();
`ifdef SOP_SELFCHECK_EN
        test_selfcheck();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
